// File: rtl/jstk2_spi_reader.sv
// rtl/jstk2_spi_reader.sv - Pmod JSTK2 SPI poller producing clamped X/Y words and button bits.
module jstk2_spi_reader #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCLK_FREQ_HZ = 500_000,
    parameter int SS_SETUP_US  = 15,
    parameter int BYTE_GAP_US  = 10,
    parameter int IDLE_US      = 10_000,
    parameter int CLAMP_MAX    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic [10:0] x_val,
    output logic [10:0] y_val,
    output logic [1:0]  btn,
    output logic        data_valid
);

    localparam int H         = CLK_FREQ_HZ / (2 * SCLK_FREQ_HZ);
    localparam int SETUP_CYC = int'((longint'(SS_SETUP_US) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000);
    localparam int GAP_CYC   = int'((longint'(BYTE_GAP_US) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000);
    localparam int IDLE_CYC  = int'((longint'(IDLE_US) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000);
    localparam int MAX_A     = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int MAX_B     = (IDLE_CYC > H) ? IDLE_CYC : H;
    localparam int MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW        = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] H_LAST     = CW'(H - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYC - 1);
    localparam logic [10:0]   CLAMP      = 11'(CLAMP_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [9:0]    raw_x;
    logic [9:0]    raw_y;
    logic [1:0]    raw_btn;
    logic [10:0]   x_clamped;
    logic [10:0]   y_clamped;

    always_comb begin
        x_clamped = ({1'b0, raw_x} > CLAMP) ? CLAMP : {1'b0, raw_x};
        y_clamped = ({1'b0, raw_y} > CLAMP) ? CLAMP : {1'b0, raw_y};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            idx        <= '0;
            shreg      <= '0;
            raw_x      <= '0;
            raw_y      <= '0;
            raw_btn    <= '0;
            SS         <= 1'b1;
            SCLK       <= 1'b0;
            x_val      <= '0;
            y_val      <= '0;
            btn        <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cnt == IDLE_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        SS    <= 1'b0;
                        state <= ST_SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == H_LAST) begin
                        cnt <= '0;
                        if (!SCLK) begin
                            // Rising SCLK edge: capture the bit the slave has held through the low phase.
                            SCLK  <= 1'b1;
                            shreg <= {shreg[6:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                case (idx)
                                    3'd0:    raw_x[7:0] <= shreg;
                                    3'd1:    raw_x[9:8] <= shreg[1:0];
                                    3'd2:    raw_y[7:0] <= shreg;
                                    3'd3:    raw_y[9:8] <= shreg[1:0];
                                    3'd4:    raw_btn    <= shreg[1:0];
                                    default: ;
                                endcase
                                state <= (idx == 3'd4) ? ST_HOLD : ST_GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == H_LAST) begin
                        cnt        <= '0;
                        SS         <= 1'b1;
                        x_val      <= x_clamped;
                        y_val      <= y_clamped;
                        btn        <= raw_btn;
                        data_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk2_spi_reader.sv
// tb/tb_jstk2_spi_reader.sv - directed bench for jstk2_spi_reader with a MISO slave model.
module tb_jstk2_spi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic [10:0] x_val;
    logic [10:0] y_val;
    logic [1:0]  btn;
    logic        data_valid;

    jstk2_spi_reader #(
        .CLK_FREQ_HZ (100_000_000),
        .SCLK_FREQ_HZ(5_000_000),
        .SS_SETUP_US (1),
        .BYTE_GAP_US (1),
        .IDLE_US     (2),
        .CLAMP_MAX   (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MISO      (MISO),
        .SS        (SS),
        .SCLK      (SCLK),
        .x_val     (x_val),
        .y_val     (y_val),
        .btn       (btn),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: first bit presented at SS fall, next bit after each SCLK fall (mode 0).
    logic [39:0] frame    = '0;
    logic        slave_bit = 1'b0;
    logic        rnd_bit   = 1'b0;
    logic        use_rnd   = 1'b1;
    logic        slave_ss  = 1'b1;
    int          bit_i     = 0;
    assign MISO = use_rnd ? rnd_bit : slave_bit;

    always @(SS or negedge SCLK) begin
        if (SS) begin
            slave_ss = 1'b1;
        end else if (slave_ss) begin
            slave_ss  = 1'b0;
            bit_i     = 0;
            slave_bit = frame[39];
        end else begin
            bit_i = bit_i + 1;
            if (bit_i < 40) slave_bit = frame[39 - bit_i];
        end
    end

    int          rise_t[40];
    int          fall_t[40];
    int          rise_n = 0, fall_n = 0, ss_falls = 0, dv_n = 0, glitch_n = 0;
    int          t_ss_fall = 0, t_ss_rise = 0, t_dv = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [10:0] prev_x = '0, prev_y = '0;

    always @(negedge clk) begin
        if (prev_ss === 1'b1 && SS === 1'b0) begin
            t_ss_fall = cyc;
            rise_n    = 0;
            fall_n    = 0;
            ss_falls  = ss_falls + 1;
        end
        if (prev_ss === 1'b0 && SS === 1'b1) t_ss_rise = cyc;
        if (prev_sclk === 1'b0 && SCLK === 1'b1) begin
            if (rise_n < 40) rise_t[rise_n] = cyc;
            rise_n = rise_n + 1;
        end
        if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
            if (fall_n < 40) fall_t[fall_n] = cyc;
            fall_n = fall_n + 1;
        end
        if (data_valid === 1'b1) begin
            dv_n = dv_n + 1;
            t_dv = cyc;
        end
        if (rst && data_valid !== 1'b1 && (x_val !== prev_x || y_val !== prev_y)) glitch_n = glitch_n + 1;
        prev_ss   = SS;
        prev_sclk = SCLK;
        prev_x    = x_val;
        prev_y    = y_val;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int budget, input string tag);
        int start = dv_n;
        int n = 0;
        while (dv_n == start && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_dv_seen"}, 32'(dv_n != start), 1);
    endtask

    task automatic wait_ss_fall(input int budget, input string tag);
        int start = ss_falls;
        int n = 0;
        while (ss_falls == start && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_ss_fall_seen"}, 32'(ss_falls != start), 1);
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_rises"},     rise_n, 40);
        check({tag, "_ss_to_sck"}, rise_t[0] - t_ss_fall, 110);
        check({tag, "_high"},      fall_t[0] - rise_t[0], 10);
        check({tag, "_low"},       rise_t[1] - fall_t[0], 10);
        check({tag, "_gap01"},     rise_t[8] - fall_t[7], 110);
        check({tag, "_gap34"},     rise_t[32] - fall_t[31], 110);
        check({tag, "_sck_to_ss"}, t_ss_rise - fall_t[39], 10);
        check({tag, "_frame_len"}, t_dv - t_ss_fall, 1310);
    endtask

    int r0, dv0, t1;

    initial begin
        // Reset held with random MISO
        use_rnd = 1'b1;
        rst     = 1'b0;
        repeat (6) begin
            @(negedge clk);
            rnd_bit = 1'($urandom_range(0, 1));
        end
        #1;
        check("rst_ss",   SS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_x",    x_val, 0);
        check("rst_y",    y_val, 0);
        check("rst_btn",  btn, 0);
        check("rst_dv",   data_valid, 0);

        // Nominal frame
        frame   = {8'h34, 8'h02, 8'hF0, 8'h01, 8'h03};
        use_rnd = 1'b0;
        rst     = 1'b1;
        r0      = cyc;
        wait_ss_fall(400, "first");
        check("idle_to_ss", t_ss_fall - r0, 200);
        dv0 = dv_n;
        wait_dv(3000, "nominal");
        check("nom_x",   x_val, 564);
        check("nom_y",   y_val, 496);
        check("nom_btn", btn, 3);
        check("nom_ss_with_dv", SS, 1);
        check_timing("nom");
        @(negedge clk); #1;
        check("nom_dv_single", data_valid, 0);
        check("nom_dv_count",  dv_n - dv0, 1);

        // Clamp above limit on both axes
        frame = {8'hFF, 8'h03, 8'hE9, 8'h03, 8'h00};
        wait_dv(3000, "clamp");
        check("clamp_x",   x_val, 1000);
        check("clamp_y",   y_val, 1000);
        check("clamp_btn", btn, 0);

        // Exactly at limit, just below, and masked upper bits
        frame = {8'hE8, 8'h03, 8'hE7, 8'hFF, 8'hFE};
        wait_dv(3000, "mask");
        check("mask_x",   x_val, 1000);
        check("mask_y",   y_val, 999);
        check("mask_btn", btn, 2);

        // Reset during byte 2 while SCLK is high
        frame = {8'h34, 8'h02, 8'hF0, 8'h01, 8'h03};
        wait_ss_fall(400, "abort");
        begin
            int n = 0;
            while (rise_n < 18 && n < 1000) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check("abort_sclk_high", SCLK, 1);
        dv0 = dv_n;
        #1 rst = 1'b0;
        #1;
        check("abort_ss",   SS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_x",    x_val, 0);
        check("abort_y",    y_val, 0);
        check("abort_btn",  btn, 0);
        check("abort_dv",   data_valid, 0);
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_dv", dv_n - dv0, 0);
        rst = 1'b1;
        wait_dv(3000, "recover");
        check("rec_x",   x_val, 564);
        check("rec_y",   y_val, 496);
        check("rec_btn", btn, 3);
        check_timing("rec");

        // Back-to-back frames
        frame = {8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
        wait_dv(3000, "b2b1");
        check("b2b1_x", x_val, 100);
        t1 = t_dv;
        frame = {8'h84, 8'h03, 8'h00, 8'h00, 8'h00};
        wait_dv(3000, "b2b2");
        check("b2b2_x",       x_val, 900);
        check("b2b_spacing",  t_dv - t1, 1510);
        check("b2b2_rises",   rise_n, 40);
        check("no_glitches",  glitch_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
